// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-requester memory arbiter: FSM state
// encoding, owner identifiers and the memory strobe width.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int MASK_LEN = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_rr.sv
// -----------------------------------------------------------------------------
// mem_arb_rr
// Two-way round-robin picker. A lone requester always wins; on a tie the
// requester that was not served last wins. The last-served register resets to
// IFU, so LSU wins the first tie after reset.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_ifu_valid    : IFU is requesting
//   i_lsu_valid    : LSU is requesting
//   i_accept       : the current grant is being taken this cycle
//   o_grant_valid  : at least one requester is present
//   o_grant_lsu    : winner (0 = IFU, 1 = LSU); meaningful with o_grant_valid
// -----------------------------------------------------------------------------
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_ifu_valid,
  input  logic i_lsu_valid,
  input  logic i_accept,
  output logic o_grant_valid,
  output logic o_grant_lsu
);

  owner_t r_last;
  owner_t w_grant;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_grant = OWN_IFU;
    if (i_ifu_valid && i_lsu_valid) begin
      w_grant = (r_last == OWN_IFU) ? OWN_LSU : OWN_IFU;
    end else if (i_lsu_valid) begin
      w_grant = OWN_LSU;
    end
  end

  assign o_grant_valid = i_ifu_valid | i_lsu_valid;
  assign o_grant_lsu   = (w_grant == OWN_LSU);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= OWN_IFU;
    end else if (i_accept) begin
      r_last <= w_grant;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between an instruction-fetch unit (IFU, read only)
// and a load/store unit (LSU). One transaction is in flight at a time:
//   IDLE -> REQ (drive memory request) -> WAIT (await completion pulse)
//        -> RESP (hand data to owner) -> IDLE
//
// Ports
//   clk, rst_n                       : clock, asynchronous active-low reset
//   ifu_req_valid/ready, ifu_addr    : IFU request handshake
//   ifu_rsp_valid/ready, ifu_rdata   : IFU response handshake
//   lsu_req_valid/ready, lsu_addr,
//   lsu_wdata, lsu_wmask             : LSU request (wmask 0 = read)
//   lsu_rsp_valid/ready, lsu_rdata   : LSU response handshake
//   mem_req_valid/ready, mem_addr,
//   mem_wdata, mem_wmask             : shared memory request
//   mem_rsp_valid, mem_rdata         : one-cycle memory completion pulse
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_LEN-1:0] ifu_addr,
  output logic                ifu_rsp_valid,
  input  logic                ifu_rsp_ready,
  output logic [DATA_LEN-1:0] ifu_rdata,

  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_LEN-1:0] lsu_addr,
  input  logic [DATA_LEN-1:0] lsu_wdata,
  input  logic [MASK_LEN-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  input  logic                lsu_rsp_ready,
  output logic [DATA_LEN-1:0] lsu_rdata,

  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic [MASK_LEN-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_LEN-1:0] mem_rdata
);

  state_t              r_state;
  state_t              w_next;
  owner_t              r_owner;
  logic [ADDR_LEN-1:0] r_addr;
  logic [DATA_LEN-1:0] r_wdata;
  logic [MASK_LEN-1:0] r_wmask;
  logic [DATA_LEN-1:0] r_ifu_rdata;
  logic [DATA_LEN-1:0] r_lsu_rdata;

  logic   w_grant_valid;
  logic   w_grant_lsu;
  owner_t w_grant;
  logic   w_accept;
  logic   w_owner_rsp_ready;

  // Arbitration is only consulted in IDLE; outside IDLE the accept is gated
  // off so the last-served register does not move.
  mem_arb_rr u_rr (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_ifu_valid   (ifu_req_valid),
    .i_lsu_valid   (lsu_req_valid),
    .i_accept      (w_accept),
    .o_grant_valid (w_grant_valid),
    .o_grant_lsu   (w_grant_lsu)
  );

  assign w_grant  = owner_t'(w_grant_lsu);
  assign w_accept = (r_state == IDLE) && w_grant_valid;

  assign w_owner_rsp_ready = (r_owner == OWN_IFU) ? ifu_rsp_ready : lsu_rsp_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and handshake outputs. mem_rsp_valid is only looked at in WAIT,
  // so stray completion pulses in any other state fall on the floor.
  always_comb begin
    w_next        = r_state;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        ifu_req_ready = w_grant_valid && (w_grant == OWN_IFU);
        lsu_req_ready = w_grant_valid && (w_grant == OWN_LSU);
        if (w_accept) w_next = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_next = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) w_next = RESP;
      end
      RESP: begin
        ifu_rsp_valid = (r_owner == OWN_IFU);
        lsu_rsp_valid = (r_owner == OWN_LSU);
        if (w_owner_rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Payload and response registers. The request payload is captured at accept
  // so the requester may change or drop its inputs while the transaction runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= OWN_IFU;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_ifu_rdata <= '0;
      r_lsu_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_owner <= w_grant;
        if (w_grant == OWN_LSU) begin
          r_addr  <= lsu_addr;
          r_wdata <= lsu_wdata;
          r_wmask <= lsu_wmask;
        end else begin
          r_addr  <= ifu_addr;
          r_wdata <= '0;
          r_wmask <= '0;
        end
      end
      if ((r_state == WAIT) && mem_rsp_valid) begin
        if (r_owner == OWN_LSU) r_lsu_rdata <= mem_rdata;
        else                    r_ifu_rdata <= mem_rdata;
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_wmask;
  assign ifu_rdata = r_ifu_rdata;
  assign lsu_rdata = r_lsu_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: directed scenarios for latency,
// arbitration, writes, stalls, response back-pressure and mid-flight reset,
// followed by randomized transactions against a transaction-level model.
// Inputs change 2 time units after the rising edge; outputs are sampled one
// unit later, well clear of the edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_ready;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rdata     (ifu_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_ready (lsu_rsp_ready),
    .lsu_rdata     (lsu_rdata),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    ifu_req_valid = 1'b0; ifu_addr = '0; ifu_rsp_ready = 1'b0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    lsu_rsp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    #7;
    rst_n = 1'b1;
    tick();
  endtask

  // Reset values, then the first tie after reset goes to LSU.
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #3;
    n_total++;
    if ({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 00000",
        {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid});
    end
    n_total++;
    if ({mem_addr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata} !== '0) begin
      n_bad++; $display("FAIL reset_data: addr=%h wdata=%h wmask=%h ifu_rdata=%h lsu_rdata=%h want all 0",
        mem_addr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata);
    end
    rst_n = 1'b1;
    tick();
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    #1;
    n_total++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
      n_bad++; $display("FAIL reset_first_tie: ifu/lsu ready got %b want 01", {ifu_req_ready, lsu_req_ready});
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    tick();
  endtask

  // Minimum-latency IFU read.
  task automatic test_ifu_read();
    do_reset();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1;
    #1;
    n_total++;
    if (ifu_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL ifu_accept: ifu_req_ready got %b want 1", ifu_req_ready);
    end
    tick();                                   // cycle 1
    ifu_req_valid = 1'b0; ifu_addr = 32'h1234_5678;
    #1;
    n_total++;
    if ({mem_req_valid, mem_addr, mem_wmask} !== {1'b1, 32'h8000_0000, 4'h0}) begin
      n_bad++; $display("FAIL ifu_mem_req: valid=%b addr=%h wmask=%h want 1 80000000 0",
        mem_req_valid, mem_addr, mem_wmask);
    end
    tick();                                   // cycle 2
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h0010_0073;
    #1;
    n_total++;
    if (ifu_rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL ifu_rsp_early: ifu_rsp_valid got %b want 0", ifu_rsp_valid);
    end
    tick();                                   // cycle 3
    mem_rsp_valid = 1'b0; mem_rdata = '0; ifu_rsp_ready = 1'b1;
    #1;
    n_total++;
    if ({ifu_rsp_valid, ifu_rdata} !== {1'b1, 32'h0010_0073}) begin
      n_bad++; $display("FAIL ifu_rsp: valid=%b rdata=%h want 1 00100073", ifu_rsp_valid, ifu_rdata);
    end
    tick();                                   // cycle 4
    ifu_rsp_ready = 1'b0; ifu_req_valid = 1'b1;
    #1;
    n_total++;
    if ({ifu_rsp_valid, ifu_req_ready, ifu_rdata} !== {1'b0, 1'b1, 32'h0010_0073}) begin
      n_bad++; $display("FAIL ifu_back_to_idle: rsp_valid=%b req_ready=%b rdata=%h want 0 1 00100073",
        ifu_rsp_valid, ifu_req_ready, ifu_rdata);
    end
    ifu_req_valid = 1'b0;
    tick();
  endtask

  // Four back-to-back ties after reset: LSU, IFU, LSU, IFU.
  task automatic test_tie();
    logic exp_lsu;
    do_reset();
    exp_lsu = 1'b1;
    for (int r = 0; r < 4; r++) begin
      ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
      ifu_addr = 32'h100 + r; lsu_addr = 32'h200 + r; lsu_wmask = 4'h0;
      #1;
      n_total++;
      if ({ifu_req_ready, lsu_req_ready} !== {~exp_lsu, exp_lsu}) begin
        n_bad++; $display("FAIL tie_grant[%0d]: ifu/lsu ready got %b want %b", r,
          {ifu_req_ready, lsu_req_ready}, {~exp_lsu, exp_lsu});
      end
      tick();
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hA000 + r;
      tick();
      mem_rsp_valid = 1'b0; ifu_rsp_ready = 1'b1; lsu_rsp_ready = 1'b1;
      #1;
      n_total++;
      if ({ifu_rsp_valid, lsu_rsp_valid} !== {~exp_lsu, exp_lsu}) begin
        n_bad++; $display("FAIL tie_rsp[%0d]: ifu/lsu rsp_valid got %b want %b", r,
          {ifu_rsp_valid, lsu_rsp_valid}, {~exp_lsu, exp_lsu});
      end
      tick();
      ifu_rsp_ready = 1'b0; lsu_rsp_ready = 1'b0;
      exp_lsu = ~exp_lsu;
    end
  endtask

  // LSU partial write.
  task automatic test_lsu_write();
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'h3;
    tick();
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0; mem_req_ready = 1'b1;
    #1;
    n_total++;
    if ({mem_req_valid, mem_addr, mem_wdata, mem_wmask} !== {1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'h3}) begin
      n_bad++; $display("FAIL lsu_write_req: valid=%b addr=%h wdata=%h wmask=%h want 1 80001000 deadbeef 3",
        mem_req_valid, mem_addr, mem_wdata, mem_wmask);
    end
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1;
    #1;
    n_total++;
    if (lsu_rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL lsu_write_early: lsu_rsp_valid got %b want 0", lsu_rsp_valid);
    end
    tick();
    mem_rsp_valid = 1'b0; lsu_rsp_ready = 1'b1;
    #1;
    n_total++;
    if ({lsu_rsp_valid, ifu_rsp_valid} !== 2'b10) begin
      n_bad++; $display("FAIL lsu_write_rsp: lsu/ifu rsp_valid got %b want 10", {lsu_rsp_valid, ifu_rsp_valid});
    end
    tick();
    lsu_rsp_ready = 1'b0;
  endtask

  // Memory back-pressure for 5 cycles with both requesters knocking.
  task automatic test_mem_stall();
    logic [31:0] a;
    a = $urandom;
    ifu_req_valid = 1'b1; ifu_addr = a;
    tick();
    lsu_req_valid = 1'b1; lsu_addr = ~a; lsu_wdata = $urandom; lsu_wmask = 4'hF; ifu_addr = ~a;
    for (int k = 0; k < 5; k++) begin
      mem_req_ready = 1'b0;
      #1;
      n_total++;
      if ({mem_req_valid, mem_addr, mem_wdata, mem_wmask, ifu_req_ready, lsu_req_ready}
          !== {1'b1, a, 32'h0, 4'h0, 1'b0, 1'b0}) begin
        n_bad++; $display("FAIL stall[%0d]: valid=%b addr=%h wdata=%h wmask=%h rdy=%b%b want 1 %h 0 0 00", k,
          mem_req_valid, mem_addr, mem_wdata, mem_wmask, ifu_req_ready, lsu_req_ready, a);
      end
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_rsp_valid = 1'b0; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; ifu_rsp_ready = 1'b1;
    #1;
    n_total++;
    if ({ifu_rsp_valid, ifu_rdata} !== {1'b1, 32'h5555_AAAA}) begin
      n_bad++; $display("FAIL stall_rsp: valid=%b rdata=%h want 1 5555aaaa", ifu_rsp_valid, ifu_rdata);
    end
    tick();
    ifu_rsp_ready = 1'b0;
  endtask

  // Response back-pressure with a stray memory completion in RESP.
  task automatic test_rsp_backpressure();
    logic [31:0] d1;
    d1 = $urandom;
    lsu_req_valid = 1'b1; lsu_addr = 32'h40; lsu_wmask = 4'h0;
    tick();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = d1;
    tick();
    for (int k = 0; k < 3; k++) begin
      mem_rsp_valid = (k == 1); mem_rdata = ~d1;
      #1;
      n_total++;
      if ({lsu_rsp_valid, lsu_rdata} !== {1'b1, d1}) begin
        n_bad++; $display("FAIL rsp_hold[%0d]: valid=%b rdata=%h want 1 %h", k, lsu_rsp_valid, lsu_rdata, d1);
      end
      tick();
    end
    mem_rsp_valid = 1'b0; lsu_rsp_ready = 1'b1;
    tick();
    lsu_rsp_ready = 1'b0;
    #1;
    n_total++;
    if ({lsu_rsp_valid, mem_req_valid, lsu_rdata} !== {1'b0, 1'b0, d1}) begin
      n_bad++; $display("FAIL rsp_release: rsp_valid=%b mem_req_valid=%b rdata=%h want 0 0 %h",
        lsu_rsp_valid, mem_req_valid, lsu_rdata, d1);
    end
    tick();
  endtask

  // Reset while waiting for memory, followed by the late completion.
  task automatic test_reset_mid();
    lsu_req_valid = 1'b1; lsu_addr = 32'h80; lsu_wmask = 4'h0;
    tick();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;                     // now in WAIT
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({mem_req_valid, mem_addr, lsu_rdata, ifu_rdata} !== '0) begin
      n_bad++; $display("FAIL reset_mid_async: mem_req_valid=%b addr=%h lsu_rdata=%h ifu_rdata=%h want 0",
        mem_req_valid, mem_addr, lsu_rdata, ifu_rdata);
    end
    rst_n = 1'b1;
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    mem_rsp_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_total++;
      if ({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, ifu_req_ready, lsu_req_ready, lsu_rdata, ifu_rdata} !== '0) begin
        n_bad++; $display("FAIL reset_mid_after[%0d]: rsp=%b%b mem_req_valid=%b rdy=%b%b lsu_rdata=%h ifu_rdata=%h want 0",
          k, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, ifu_req_ready, lsu_req_ready, lsu_rdata, ifu_rdata);
      end
      tick();
    end
  endtask

  // Randomized transactions against a transaction-level model: the model only
  // knows "who was served last" and "what each requester last received".
  task automatic test_random();
    logic        m_last_lsu;
    logic [31:0] m_rd [2];
    logic        want_ifu, want_lsu, win;
    logic [31:0] a_i, a_l, wd, rd, exp_addr, exp_wd;
    logic [3:0]  wm, exp_wm;
    int          n_stall, n_wait, n_bp;
    do_reset();
    m_last_lsu = 1'b0;
    m_rd[0] = '0; m_rd[1] = '0;
    for (int t = 0; t < 40; t++) begin
      {want_lsu, want_ifu} = 2'($urandom_range(1, 3));
      a_i = $urandom; a_l = $urandom; wd = $urandom; wm = 4'($urandom);
      win = (want_ifu && want_lsu) ? ~m_last_lsu : want_lsu;
      exp_addr = win ? a_l : a_i;
      exp_wd   = win ? wd : '0;
      exp_wm   = win ? wm : '0;
      ifu_req_valid = want_ifu; ifu_addr = a_i;
      lsu_req_valid = want_lsu; lsu_addr = a_l; lsu_wdata = wd; lsu_wmask = wm;
      #1;
      n_total++;
      if ({ifu_req_ready, lsu_req_ready} !== {~win, win}) begin
        n_bad++; $display("FAIL rnd_grant[%0d]: ifu/lsu ready got %b want %b", t,
          {ifu_req_ready, lsu_req_ready}, {~win, win});
      end
      tick();
      // The winner drops out; the loser may keep knocking.
      if (win) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
      if ($urandom_range(0, 1) == 0) begin ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; end
      ifu_addr = $urandom; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
      n_stall = $urandom_range(0, 3);
      for (int k = 0; k <= n_stall; k++) begin
        mem_req_ready = (k == n_stall);
        mem_rsp_valid = 1'($urandom); mem_rdata = $urandom;
        #1;
        n_total++;
        if ({mem_req_valid, mem_addr, mem_wdata, mem_wmask, ifu_req_ready, lsu_req_ready}
            !== {1'b1, exp_addr, exp_wd, exp_wm, 2'b00}) begin
          n_bad++; $display("FAIL rnd_req[%0d]: valid=%b addr=%h wdata=%h wmask=%h rdy=%b%b want 1 %h %h %h 00",
            t, mem_req_valid, mem_addr, mem_wdata, mem_wmask, ifu_req_ready, lsu_req_ready,
            exp_addr, exp_wd, exp_wm);
        end
        tick();
      end
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      n_wait = $urandom_range(0, 2);
      for (int k = 0; k < n_wait; k++) begin
        #1;
        n_total++;
        if ({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid} !== 3'b000) begin
          n_bad++; $display("FAIL rnd_wait[%0d]: rsp=%b%b mem_req_valid=%b want 000", t,
            ifu_rsp_valid, lsu_rsp_valid, mem_req_valid);
        end
        tick();
      end
      rd = $urandom;
      mem_rsp_valid = 1'b1; mem_rdata = rd;
      tick();
      m_rd[win] = rd;
      n_bp = $urandom_range(0, 2);
      for (int k = 0; k <= n_bp; k++) begin
        mem_rsp_valid = 1'($urandom); mem_rdata = $urandom;
        if (win) begin lsu_rsp_ready = (k == n_bp); ifu_rsp_ready = 1'($urandom); end
        else     begin ifu_rsp_ready = (k == n_bp); lsu_rsp_ready = 1'($urandom); end
        #1;
        n_total++;
        if ({ifu_rsp_valid, lsu_rsp_valid, ifu_rdata, lsu_rdata} !== {~win, win, m_rd[0], m_rd[1]}) begin
          n_bad++; $display("FAIL rnd_rsp[%0d]: rsp=%b%b ifu_rdata=%h lsu_rdata=%h want %b%b %h %h", t,
            ifu_rsp_valid, lsu_rsp_valid, ifu_rdata, lsu_rdata, ~win, win, m_rd[0], m_rd[1]);
        end
        tick();
      end
      m_last_lsu = win;
      idle_inputs();
    end
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_tie();
    test_lsu_write();
    test_mem_stall();
    test_rsp_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
